toggle_bank: RTL and testbench

TOGGLE_BANK -- requirements
Module: toggle_bank

---
 rtl/toggle_bank.sv | 131 +++++++++++++
 tb/tb_toggle_bank.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_bank.sv
// toggle_bank: WIDTH independent toggle channels with force/lock/load controls,
// tick-driven auto-clear, registered edge pulses, saturating rise count and popcount.
module toggle_chan #(
    parameter int AGE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             t,
    input  logic             set,
    input  logic             clr,
    input  logic             lock,
    input  logic             load,
    input  logic             load_bit,
    input  logic             tick,
    input  logic [AGE_W-1:0] timeout,
    output logic             q,
    output logic             q_nxt
);
    logic [AGE_W-1:0] age, age_nxt;
    logic             expire;

    // age counts ticks already spent high; expiring when it reaches timeout-1
    // keeps the bit high for exactly timeout ticks
    assign expire = (timeout != '0) && tick && q && (age == timeout - AGE_W'(1));

    always_comb begin
        q_nxt   = q;
        age_nxt = age;
        if (load) begin
            q_nxt   = load_bit;
            age_nxt = '0;
        end else if (en && !lock) begin
            if (clr)         q_nxt = 1'b0;
            else if (set)    q_nxt = 1'b1;
            else if (t)      q_nxt = ~q;
            else if (expire) q_nxt = 1'b0;

            if (!q_nxt || set || t)
                age_nxt = '0;
            else if (tick && (age != '1))
                age_nxt = age + AGE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q   <= 1'b0;
            age <= '0;
        end else begin
            q   <= q_nxt;
            age <= age_nxt;
        end
    end
endmodule

module toggle_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8,
    parameter int AGE_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [WIDTH-1:0]           t,
    input  logic [WIDTH-1:0]           set,
    input  logic [WIDTH-1:0]           clr,
    input  logic [WIDTH-1:0]           lock,
    input  logic                       load,
    input  logic [WIDTH-1:0]           load_data,
    input  logic                       tick,
    input  logic [AGE_W-1:0]           timeout,
    input  logic                       cnt_clr,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           rise,
    output logic [WIDTH-1:0]           fall,
    output logic [CNT_W-1:0]           rise_cnt,
    output logic [$clog2(WIDTH+1)-1:0] ones
);
    localparam int ONES_W = $clog2(WIDTH+1);
    localparam int SUM_W  = ((CNT_W > ONES_W) ? CNT_W : ONES_W) + 1;

    function automatic logic [ONES_W-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [ONES_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + ONES_W'(v[i]);
        return c;
    endfunction

    logic [WIDTH-1:0]  q_nxt;
    logic [ONES_W-1:0] n_rise;
    logic [SUM_W-1:0]  cnt_sum;
    logic [CNT_W-1:0]  cnt_nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        toggle_chan #(.AGE_W(AGE_W)) u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .t       (t[i]),
            .set     (set[i]),
            .clr     (clr[i]),
            .lock    (lock[i]),
            .load    (load),
            .load_bit(load_data[i]),
            .tick    (tick),
            .timeout (timeout),
            .q       (q[i]),
            .q_nxt   (q_nxt[i])
        );
    end

    // several channels can rise on one edge, so add the count, not a single step
    assign n_rise  = popcnt(q_nxt & ~q);
    assign cnt_sum = SUM_W'(rise_cnt) + SUM_W'(n_rise);
    assign cnt_nxt = (cnt_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise     <= '0;
            fall     <= '0;
            rise_cnt <= '0;
            ones     <= '0;
        end else begin
            rise     <= q_nxt & ~q;
            fall     <= ~q_nxt & q;
            ones     <= popcnt(q);
            rise_cnt <= cnt_clr ? '0 : cnt_nxt;
        end
    end
endmodule

// File: tb/tb_toggle_bank.sv
// tb_toggle_bank: scoreboard bench; a behavioural model queues expected outputs per
// edge, directed scenarios add fixed-value checks, then a random phase.
module tb_toggle_bank;
    localparam int W  = 8;
    localparam int CW = 4;
    localparam int AW = 4;
    localparam int AGE_MAX = (1 << AW) - 1;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en, load, tick, cnt_clr;
    logic [W-1:0]  t, set, clr, lock, load_data;
    logic [AW-1:0] timeout;
    logic [W-1:0]  q, rise, fall;
    logic [CW-1:0] rise_cnt;
    logic [3:0]    ones;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0]  q, rise, fall;
        logic [CW-1:0] cnt;
        logic [3:0]    ones;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] mq;
    int           mage[W];
    int           mcnt;

    toggle_bank #(.WIDTH(W), .CNT_W(CW), .AGE_W(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .t        (t),
        .set      (set),
        .clr      (clr),
        .lock     (lock),
        .load     (load),
        .load_data(load_data),
        .tick     (tick),
        .timeout  (timeout),
        .cnt_clr  (cnt_clr),
        .q        (q),
        .rise     (rise),
        .fall     (fall),
        .rise_cnt (rise_cnt),
        .ones     (ones)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic idle();
        en = 1'b1; t = '0; set = '0; clr = '0; lock = '0;
        load = 1'b0; load_data = '0; tick = 1'b0; timeout = '0; cnt_clr = 1'b0;
    endtask

    task automatic model_clear();
        mq   = '0;
        mcnt = 0;
        for (int i = 0; i < W; i++) mage[i] = 0;
    endtask

    // model the coming edge, queue the expectation, clock, then pop and compare
    task automatic step();
        exp_t         e;
        logic [W-1:0] nq;
        int           na[W];
        int           nr;
        for (int i = 0; i < W; i++) begin
            nq[i] = mq[i];
            na[i] = mage[i];
            if (load) begin
                nq[i] = load_data[i];
                na[i] = 0;
            end else if (en && !lock[i]) begin
                if (clr[i])      nq[i] = 1'b0;
                else if (set[i]) nq[i] = 1'b1;
                else if (t[i])   nq[i] = ~mq[i];
                else if (timeout != 0 && tick && mq[i] && (mage[i] + 1 == int'(timeout)))
                    nq[i] = 1'b0;
                if (!nq[i] || set[i] || t[i]) na[i] = 0;
                else if (tick && mage[i] < AGE_MAX) na[i] = mage[i] + 1;
            end
        end
        nr     = $countones(nq & ~mq);
        e.q    = nq;
        e.rise = nq & ~mq;
        e.fall = mq & ~nq;
        e.ones = 4'($countones(mq));
        e.cnt  = cnt_clr ? '0 : CW'((mcnt + nr > CNT_MAX) ? CNT_MAX : mcnt + nr);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        mq   = nq;
        mage = na;
        mcnt = int'(e.cnt);
        e = sbq.pop_front();
        chk("sb_q",    32'(q),        32'(e.q));
        chk("sb_rise", 32'(rise),     32'(e.rise));
        chk("sb_fall", 32'(fall),     32'(e.fall));
        chk("sb_cnt",  32'(rise_cnt), 32'(e.cnt));
        chk("sb_ones", 32'(ones),     32'(e.ones));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        idle();
        model_clear();
        #12;
        chk("rst_q",    32'(q),        32'h0);
        chk("rst_rise", 32'(rise),     32'h0);
        chk("rst_fall", 32'(fall),     32'h0);
        chk("rst_cnt",  32'(rise_cnt), 32'h0);
        chk("rst_ones", 32'(ones),     32'h0);
        @(negedge clk) reset = 1'b0;

        // basic toggle of low nibble
        t = 8'h0F; step();
        chk("t_q",    32'(q),        32'h0F);
        chk("t_rise", 32'(rise),     32'h0F);
        chk("t_cnt",  32'(rise_cnt), 32'd4);
        t = '0; step();
        chk("t_ones", 32'(ones), 32'd4);
        chk("t_rise0", 32'(rise), 32'h0);

        // clr beats set beats toggle
        clr = 8'h0E; step(); clr = '0;
        set = 8'h01; clr = 8'h01; t = 8'h01; step();
        chk("pri_q",    32'(q),        32'h00);
        chk("pri_fall", 32'(fall),     32'h01);
        chk("pri_cnt",  32'(rise_cnt), 32'd4);
        idle();

        // auto-clear after exactly timeout ticks
        timeout = 4'd3;
        set = 8'h04; step(); set = '0;
        tick = 1'b1;
        step(); chk("to_t1", 32'(q[2]), 32'd1);
        step(); chk("to_t2", 32'(q[2]), 32'd1);
        step(); chk("to_t3", 32'(q[2]), 32'd0);
        tick = 1'b0; timeout = '0;
        set = 8'h04; step(); set = '0;
        tick = 1'b1;
        repeat (20) step();
        chk("to_off", 32'(q), 32'h04);
        idle();

        // lock blocks everything but load
        clr = 8'hFF; step(); clr = '0;
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        lock = 8'hFF; t = 8'hFF; set = 8'hFF; clr = 8'hFF; tick = 1'b1; timeout = 4'd1;
        step();
        chk("lk_q", 32'(q), 32'h00);
        load = 1'b1; load_data = 8'hA5; step();
        chk("lk_load",  32'(q),        32'hA5);
        chk("lk_cnt",   32'(rise_cnt), 32'd4);
        chk("lk_rise",  32'(rise),     32'hA5);
        idle();

        // global disable holds state; cnt_clr still acts
        en = 1'b0; t = 8'hFF; set = 8'hFF; tick = 1'b1; timeout = 4'd1;
        step();
        chk("en_q",    32'(q),    32'hA5);
        chk("en_rise", 32'(rise), 32'h0);
        cnt_clr = 1'b1; step();
        chk("en_cclr", 32'(rise_cnt), 32'd0);
        idle();

        // saturation of the rise counter
        clr = 8'hFF; step(); clr = '0;
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        t = 8'h01;
        repeat (40) step();
        chk("sat_cnt", 32'(rise_cnt), 32'd15);
        t = '0; cnt_clr = 1'b1; step();
        chk("sat_clr", 32'(rise_cnt), 32'd0);
        idle();

        // asynchronous reset mid-cycle
        load = 1'b1; load_data = 8'hFF; step(); idle();
        tick = 1'b1; timeout = 4'd2;
        #2 reset = 1'b1;
        #1;
        chk("ar_q",    32'(q),        32'h0);
        chk("ar_rise", 32'(rise),     32'h0);
        chk("ar_cnt",  32'(rise_cnt), 32'h0);
        chk("ar_ones", 32'(ones),     32'h0);
        model_clear();
        @(negedge clk) reset = 1'b0;
        step();
        chk("ar_rel_rise", 32'(rise), 32'h0);
        chk("ar_rel_fall", 32'(fall), 32'h0);
        idle();

        // random mix against the model
        for (int n = 0; n < 300; n++) begin
            en        = ($urandom_range(0, 7) != 0);
            t         = W'($urandom);
            set       = W'($urandom & $urandom & $urandom);
            clr       = W'($urandom & $urandom & $urandom);
            lock      = W'($urandom & $urandom & $urandom);
            load      = ($urandom_range(0, 15) == 0);
            load_data = W'($urandom);
            tick      = $urandom_range(0, 1) == 1;
            timeout   = AW'($urandom_range(0, 4));
            cnt_clr   = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 1) == 1) t = '0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
